// File: rtl/frac_clk_pkg.sv
// frac_clk_en_gen shared definitions.
// State encoding and default datapath width.
package frac_clk_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        PEND = ST_PEND
    } state_e;

endpackage

// File: rtl/frac_clk_en_gen_if.sv
// Control/status bundle of the fractional clock-enable generator.
// master drives config and enable, slave is the generator.
interface frac_clk_en_gen_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] cfg_num;
    logic [WIDTH-1:0] cfg_den;
    logic             cfg_load;
    logic             cfg_ack;
    logic             cfg_err;
    logic             clk_en_out;
    logic             clk_div_out;
    logic             period_start;
    logic             busy;

    modport master (
        output enable, cfg_num, cfg_den, cfg_load,
        input  cfg_ack, cfg_err, clk_en_out, clk_div_out,
        input  period_start, busy
    );

    modport slave (
        input  enable, cfg_num, cfg_den, cfg_load,
        output cfg_ack, cfg_err, clk_en_out, clk_div_out,
        output period_start, busy
    );
endinterface

// File: rtl/frac_acc.sv
// Phase accumulator: adds num each run cycle, subtracts den on overflow.
// pulse/wrap describe the step the accumulator takes at the next edge.
module frac_acc
    import frac_clk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] num_i,
    input  logic [WIDTH-1:0] den_i,
    input  logic             run_i,
    input  logic             clear_i,
    output logic             pulse_o,
    output logic             wrap_o
);
    logic [WIDTH:0] acc_q;
    logic [WIDTH:0] acc_d;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] nxt;

    // Candidate next accumulator value and the pulse decision.
    always_comb begin
        sum     = acc_q + {1'b0, num_i};
        pulse_o = (sum >= {1'b0, den_i});
        nxt     = pulse_o ? (sum - {1'b0, den_i}) : sum;
        wrap_o  = (nxt == '0);
    end

    // Clear has priority so an idle generator always restarts from phase 0.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (run_i) begin
            acc_d = nxt;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/frac_clk_en_gen.sv
// Fractional clock-enable generator: num/den enable stream plus toggle clock.
// New ratios are staged and only take effect at a period boundary.
module frac_clk_en_gen
    import frac_clk_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int RST_NUM = 1,
    parameter int RST_DEN = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    frac_clk_en_gen_if.slave  bus
);
    localparam logic [WIDTH-1:0] RNUM = WIDTH'(RST_NUM);
    localparam logic [WIDTH-1:0] RDEN = WIDTH'(RST_DEN);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] pnum_q, pnum_d;
    logic [WIDTH-1:0] pden_q, pden_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             en_q, en_d;
    logic             div_q, div_d;
    logic             ps_q, ps_d;
    logic             cfg_ok;
    logic             run;
    logic             clear;
    logic             pulse;
    logic             wrap;

    frac_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .num_i   (num_q),
        .den_i   (den_q),
        .run_i   (run),
        .clear_i (clear),
        .pulse_o (pulse),
        .wrap_o  (wrap)
    );

    // Load validation: nonzero denominator and a ratio of at most one.
    always_comb begin
        cfg_ok = bus.cfg_load && (bus.cfg_den != '0) &&
                 (bus.cfg_num <= bus.cfg_den);
    end

    // FSM next state, config shadowing and output decisions.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        pnum_d  = pnum_q;
        pden_d  = pden_q;
        ack_d   = 1'b0;
        err_d   = bus.cfg_load && !cfg_ok;
        en_d    = 1'b0;
        ps_d    = 1'b0;
        div_d   = div_q;
        run     = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (cfg_ok) begin
                    num_d = bus.cfg_num;
                    den_d = bus.cfg_den;
                    ack_d = 1'b1;
                end
                if (bus.enable) begin
                    state_d = RUN;
                end
            end
            RUN, PEND: begin
                if (!bus.enable) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                    if (cfg_ok) begin
                        num_d = bus.cfg_num;
                        den_d = bus.cfg_den;
                        ack_d = 1'b1;
                    end else if (state_q == PEND) begin
                        num_d = pnum_q;
                        den_d = pden_q;
                        ack_d = 1'b1;
                    end
                end else begin
                    run   = 1'b1;
                    en_d  = pulse;
                    ps_d  = wrap;
                    div_d = div_q ^ pulse;
                    if (state_q == PEND && wrap) begin
                        num_d   = pnum_q;
                        den_d   = pden_q;
                        ack_d   = 1'b1;
                        state_d = cfg_ok ? PEND : RUN;
                    end else if (cfg_ok) begin
                        state_d = PEND;
                    end
                    if (cfg_ok) begin
                        pnum_d = bus.cfg_num;
                        pden_d = bus.cfg_den;
                    end
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State, config and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            num_q   <= RNUM;
            den_q   <= RDEN;
            pnum_q  <= RNUM;
            pden_q  <= RDEN;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            div_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            pnum_q  <= pnum_d;
            pden_q  <= pden_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            en_q    <= en_d;
            div_q   <= div_d;
            ps_q    <= ps_d;
        end
    end

    assign bus.cfg_ack      = ack_q;
    assign bus.cfg_err      = err_q;
    assign bus.clk_en_out   = en_q;
    assign bus.clk_div_out  = div_q;
    assign bus.period_start = ps_q;
    assign bus.busy         = (state_q == PEND);
endmodule

// File: doc/frac_clk_en_gen.md
# frac_clk_en_gen

Synchronous fractional clock-enable generator. It produces a single-cycle enable stream at an average rate of num/den of sys_clk, plus a toggle clock derived from that stream. Downstream logic uses it as the all-synchronous alternative to the dual-edge 1.5 divider: num=2, den=3 gives the same average rate with no gated or inverted clocks. The num/den ratio is programmable at run time, and new ratios apply only at a period boundary, so no pulse is cut short.

## Interface
- WIDTH, 8, width of num/den and accumulator magnitude
- RST_NUM, 1, numerator active after reset
- RST_DEN, 2, denominator active after reset
- sys_clk  input  1  system clock, all logic on posedge
- sys_rst_n  input  1  asynchronous active-low reset
- enable  input  1  level; 1 = generate pulses
- cfg_num  input  WIDTH  requested numerator
- cfg_den  input  WIDTH  requested denominator
- cfg_load  input  1  single-cycle request to load cfg_num/cfg_den
- cfg_ack  output  1  one-cycle pulse when a pending config becomes active
- cfg_err  output  1  one-cycle pulse when a load is rejected
- clk_en_out  output  1  fractional enable pulse, registered
- clk_div_out  output  1  toggles on every clk_en_out pulse, registered
- period_start  output  1  pulse when the accumulator returns to 0
- busy  output  1  1 while a pending config awaits a boundary

## Operation
- Clocking: one clock (sys_clk); reset is asynchronous and active-low (sys_rst_n). These are fixed.
- Reset values:
  - Outputs: all outputs 0.
  - Accumulator: acc = 0.
  - Active config: act_num = RST_NUM, act_den = RST_DEN.
  - Pending config: none; state IDLE.
- Validity: a config is valid when cfg_den != 0 and cfg_num <= cfg_den.
  - Invalid load: cfg_err pulses on the next cycle, the load is discarded, and any existing pending config is kept.
- Accumulator (WIDTH+1 bits): s = acc + act_num.
  - If s >= act_den, the pulse term is 1 and acc <= s - act_den.
  - Otherwise the pulse term is 0 and acc <= s.
  - No overflow is possible because act_num <= act_den < 2^WIDTH.
- Registered outputs:
  - clk_en_out <= pulse term.
  - period_start <= (next acc == 0).
- States:
  - IDLE (enable=0): acc held at 0; clk_en_out and period_start are 0; clk_div_out holds its value.
  - RUN: accumulates on every edge.
  - PEND: RUN with a pending config; busy=1.
- Transitions:
  - IDLE -> RUN on enable=1.
  - RUN -> PEND on a valid cfg_load.
  - PEND -> RUN at the edge where the next acc == 0. The pending values become active there and cfg_ack pulses.
  - RUN/PEND -> IDLE on enable=0. acc clears; a pending config is applied immediately with cfg_ack.
- Load while IDLE: a valid cfg_load applies on the next edge with cfg_ack; no PEND state is entered.
- Load while PEND: a second valid load overwrites the pending values (latest wins), with a single cfg_ack.
- Special ratios:
  - num == den: clk_en_out is constantly 1.
  - num == 0: clk_en_out is never 1, and period_start pulses every cycle.

## Timing
- Enable start: enable is sampled high at edge k and the state becomes RUN. The first accumulation is at edge k+1, so clk_en_out can first be high during cycle k+1..k+2.
- Enable stop: enable is sampled low at edge k; clk_en_out is 0 from edge k onward.
- Config application: cfg_ack, busy falling, and the new ratio all take effect at the same edge. The first pulse decision using the new ratio is at the following edge.
- Simultaneous events:
  - Boundary and a new cfg_load on the same edge: the old pending config applies, and the new load becomes pending.
  - cfg_load and enable falling on the same edge: the load is applied immediately.
- Reset mid-run: all state returns to reset values asynchronously, and the ratio reverts to RST_NUM/RST_DEN.

## Structure
- Package frac_clk_pkg holds the state encoding localparams (IDLE, RUN, PEND) and the WIDTH default.
- Sub-module frac_acc holds the accumulator datapath:
  - Inputs: num, den, run, clear.
  - Outputs: pulse, wrap.
- The top level holds the FSM, the config shadow registers, and the output registers.

## Test plan
- Divide by 1.5: num=2, den=3, enable=1 -> clk_en_out repeats 0,1,1; clk_div_out period 3 cycles; period_start every 3 cycles.
- Reset default: no load, enable=1 -> ratio 1/2, clk_en_out alternates 0,1; clk_div_out period 4 cycles.
- Invalid loads: cfg_den=0, then cfg_num=5 with cfg_den=4 -> two cfg_err pulses; ratio unchanged; busy stays 0.
- Boundary update: running 3/8, load 1/1 mid-period -> busy=1 until acc wraps; cfg_ack at the wrap edge; then clk_en_out is constant 1.
- Enable drop with pending config: enable drops while in PEND -> immediate cfg_ack; clk_en_out=0; a later enable starts with the new ratio from acc=0.
- Reset mid-run: reset asserted mid-pattern -> all outputs 0 immediately; after release with enable=1, the 1/2 pattern restarts.
